// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU function codes, FSM states
// and the instruction classifier used at accept time.
package ex_stage_pkg;

  localparam int FUNC_ADD = 0;
  localparam int FUNC_SUB = 1;
  localparam int FUNC_AND = 2;
  localparam int FUNC_OR  = 3;
  localparam int FUNC_XOR = 4;
  localparam int FUNC_SHL = 5;
  localparam int FUNC_SHR = 6;
  localparam int FUNC_MUL = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALTED = 2'd3
  } ex_state_e;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_MUL  = 2'd1,
    OP_MEM  = 2'd2,
    OP_HALT = 2'd3
  } op_class_e;

  // halt beats memory beats multiply; anything else retires in one cycle
  function automatic op_class_e classify(input logic halt, input logic rd,
                                         input logic wr, input logic mul);
    if (halt)      return OP_HALT;
    if (rd || wr)  return OP_MEM;
    if (mul)       return OP_MUL;
    return OP_ALU;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Data-memory request/ack bus between the execute stage and data memory.
interface ex_stage_if #(
  parameter int addr_width = 10,
  parameter int reg_width  = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [addr_width-1:0] dmem_addr;
  logic [reg_width-1:0]  dmem_wdata;
  logic [reg_width-1:0]  dmem_rdata;
  logic                  dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle; done flags the final
// step so the caller can capture product on the same edge busy clears.
module ex_mul_iter #(
  parameter int reg_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [reg_width-1:0] a,
  input  logic [reg_width-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [reg_width-1:0] product
);
  localparam int CW = $clog2(reg_width + 1);

  logic [reg_width-1:0] acc, mcand, mplier, step_acc;
  logic [CW-1:0]        cnt;

  assign step_acc = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CW'(reg_width - 1));
  assign product  = step_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/constant ops, iterative multiply, memory
// access over the req/ack bus, and sticky halt; drives a registered writeback.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int pc_width    = 10,
  parameter int func_width  = 6,
  parameter int const_width = 8,
  parameter int index_width = 3,
  parameter int reg_width   = 32,
  parameter int addr_width  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [pc_width-1:0]    pc_curr_ex,
  input  logic [func_width-1:0]  func_ex,
  input  logic [const_width-1:0] const_ex,
  input  logic                   memRead_ex,
  input  logic                   memWrite_ex,
  input  logic                   aluToReg_ex,
  input  logic                   constToReg_ex,
  input  logic                   aluEn_ex,
  input  logic                   halt_ex,
  input  logic                   regWrite_ex,
  input  logic [index_width-1:0] op0_ex,
  input  logic [reg_width-1:0]   S1_ex,
  input  logic [reg_width-1:0]   S2_ex,
  output logic                   stall,
  ex_stage_if.master             dmem,
  output logic                   wb_valid,
  output logic                   wb_regWrite,
  output logic [index_width-1:0] wb_dest,
  output logic [reg_width-1:0]   wb_data,
  output logic [pc_width-1:0]    wb_pc,
  output logic                   halted
);
  ex_state_e state, state_next;
  op_class_e cls;

  logic                   accept, mul_start, mul_busy, mul_done;
  logic [reg_width-1:0]   mul_product, alu_res, sc_data;
  logic [index_width-1:0] dest_q;
  logic [pc_width-1:0]    pc_q;
  logic                   regwr_q;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign cls       = classify(halt_ex, memRead_ex, memWrite_ex,
                              aluEn_ex && (func_ex == func_width'(FUNC_MUL)));
  assign mul_start = accept && (cls == OP_MUL);
  assign stall     = (state != ST_IDLE);

  ex_mul_iter #(.reg_width(reg_width)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (S1_ex),
    .b       (S2_ex),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    if (aluEn_ex) begin
      case (func_ex)
        func_width'(FUNC_ADD): alu_res = S1_ex + S2_ex;
        func_width'(FUNC_SUB): alu_res = S1_ex - S2_ex;
        func_width'(FUNC_AND): alu_res = S1_ex & S2_ex;
        func_width'(FUNC_OR):  alu_res = S1_ex | S2_ex;
        func_width'(FUNC_XOR): alu_res = S1_ex ^ S2_ex;
        func_width'(FUNC_SHL): alu_res = S1_ex << S2_ex[4:0];
        func_width'(FUNC_SHR): alu_res = S1_ex >> S2_ex[4:0];
        default:               alu_res = '0;
      endcase
    end
    sc_data = '0;
    if (aluToReg_ex)        sc_data = alu_res;
    else if (constToReg_ex) sc_data = reg_width'(const_ex);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          case (cls)
            OP_HALT: state_next = ST_HALTED;
            OP_MEM:  state_next = ST_MEM;
            OP_MUL:  state_next = ST_MUL;
            default: state_next = ST_IDLE;
          endcase
        end
      end
      // !mul_busy only guards against a lost multiplier; done ends MUL normally
      ST_MUL:    if (mul_done || !mul_busy) state_next = ST_IDLE;
      ST_MEM:    if (dmem.dmem_ack) state_next = ST_IDLE;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid        <= 1'b0;
      wb_regWrite     <= 1'b0;
      wb_dest         <= '0;
      wb_data         <= '0;
      wb_pc           <= '0;
      halted          <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dest_q          <= '0;
      pc_q            <= '0;
      regwr_q         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dest_q  <= op0_ex;
            pc_q    <= pc_curr_ex;
            regwr_q <= regWrite_ex;
            case (cls)
              OP_HALT: halted <= 1'b1;
              OP_MEM: begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= !memRead_ex;
                dmem.dmem_addr  <= S1_ex[addr_width-1:0];
                dmem.dmem_wdata <= S2_ex;
              end
              OP_ALU: begin
                wb_valid    <= 1'b1;
                wb_regWrite <= regWrite_ex;
                wb_dest     <= op0_ex;
                wb_pc       <= pc_curr_ex;
                wb_data     <= sc_data;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            wb_valid    <= 1'b1;
            wb_regWrite <= regwr_q;
            wb_dest     <= dest_q;
            wb_pc       <= pc_q;
            wb_data     <= mul_product;
          end
        end
        ST_MEM: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_dest       <= dest_q;
            wb_pc         <= pc_q;
            if (!dmem.dmem_we) begin
              wb_data     <= dmem.dmem_rdata;
              wb_regWrite <= regwr_q;
            end else begin
              wb_regWrite <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against an arithmetic reference
// model, with a scripted data-memory responder.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [9:0]  pc_curr_ex;
  logic [5:0]  func_ex;
  logic [7:0]  const_ex;
  logic        memRead_ex, memWrite_ex, aluToReg_ex, constToReg_ex;
  logic        aluEn_ex, halt_ex, regWrite_ex;
  logic [2:0]  op0_ex;
  logic [31:0] S1_ex, S2_ex;
  logic        stall, wb_valid, wb_regWrite, halted;
  logic [2:0]  wb_dest;
  logic [31:0] wb_data;
  logic [9:0]  wb_pc;

  int checks = 0;
  int errors = 0;

  ex_stage_if #(.addr_width(10), .reg_width(32)) dmem ();

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc_curr_ex(pc_curr_ex),
    .func_ex(func_ex), .const_ex(const_ex), .memRead_ex(memRead_ex),
    .memWrite_ex(memWrite_ex), .aluToReg_ex(aluToReg_ex),
    .constToReg_ex(constToReg_ex), .aluEn_ex(aluEn_ex), .halt_ex(halt_ex),
    .regWrite_ex(regWrite_ex), .op0_ex(op0_ex), .S1_ex(S1_ex), .S2_ex(S2_ex),
    .stall(stall), .dmem(dmem), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_dest(wb_dest), .wb_data(wb_data), .wb_pc(wb_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt, rd, wr, a2r, c2r, en, rw;
    logic [5:0]  func;
    logic [7:0]  cnst;
    logic [2:0]  op0;
    logic [31:0] s1, s2;
    logic [9:0]  pc;
  } instr_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t blank();
    instr_t i;
    i.halt = 0; i.rd = 0; i.wr = 0; i.a2r = 0; i.c2r = 0; i.en = 0; i.rw = 0;
    i.func = 0; i.cnst = 0; i.op0 = 0; i.s1 = 0; i.s2 = 0; i.pc = 0;
    return i;
  endfunction

  // Reference: what an ALU op produces, from the instruction-set definition
  function automatic logic [31:0] ref_alu(input instr_t i);
    if (!i.en) return 32'd0;
    case (int'(i.func))
      0: return i.s1 + i.s2;
      1: return i.s1 - i.s2;
      2: return i.s1 & i.s2;
      3: return i.s1 | i.s2;
      4: return i.s1 ^ i.s2;
      5: return i.s1 << i.s2[4:0];
      6: return i.s1 >> i.s2[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input instr_t i);
    halt_ex = i.halt; memRead_ex = i.rd; memWrite_ex = i.wr;
    aluToReg_ex = i.a2r; constToReg_ex = i.c2r; aluEn_ex = i.en;
    regWrite_ex = i.rw; func_ex = i.func; const_ex = i.cnst; op0_ex = i.op0;
    S1_ex = i.s1; S2_ex = i.s2; pc_curr_ex = i.pc;
  endtask

  task automatic exec(input instr_t i, input int dly, input logic [31:0] rdat);
    logic [31:0] exp;
    logic        exp_rw;
    bit          store;
    int          n;
    store = 0;
    @(negedge clk);
    drive(i);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    if (i.halt) begin
      chk("halt_flag", halted, 1);
      chk("halt_stall", stall, 1);
      chk("halt_no_wb", wb_valid, 0);
      return;
    end
    if (i.rd || i.wr) begin
      store = !i.rd;
      chk("mem_we", dmem.dmem_we, store);
      if (store) chk("mem_wdata", dmem.dmem_wdata, i.s2);
      for (int k = 0; k < dly; k++) begin
        chk("mem_req_held", dmem.dmem_req, 1);
        chk("mem_addr", dmem.dmem_addr, i.s1[9:0]);
        chk("mem_stall", stall, 1);
        if (k == dly - 1) begin
          dmem.dmem_ack = 1; dmem.dmem_rdata = rdat;
        end
        @(negedge clk);
      end
      dmem.dmem_ack = 0;
      dmem.dmem_rdata = $urandom;
      chk("mem_req_drop", dmem.dmem_req, 0);
      exp = rdat;
      exp_rw = store ? 1'b0 : i.rw;
    end else if (i.en && i.func == 6'd7) begin
      n = 0;
      while (stall === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("mul_stall_cycles", n, 32);
      exp = i.s1 * i.s2;
      exp_rw = i.rw;
    end else begin
      chk("alu_no_stall", stall, 0);
      exp = i.a2r ? ref_alu(i) : (i.c2r ? {24'd0, i.cnst} : 32'd0);
      exp_rw = i.rw;
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_dest", wb_dest, i.op0);
    chk("wb_pc", wb_pc, i.pc);
    chk("wb_regWrite", wb_regWrite, exp_rw);
    if (!store) chk("wb_data", wb_data, exp);
    @(negedge clk);
    chk("wb_pulse_end", wb_valid, 0);
    chk("wb_hold_dest", wb_dest, i.op0);
    if (!store) chk("wb_hold_data", wb_data, exp);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t i;
    rst_n = 0; in_valid = 0; dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
    drive(blank());
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_addr", dmem.dmem_addr, 0);
    @(negedge clk);
    rst_n = 1;

    // bubble and stray ack in IDLE
    @(negedge clk);
    dmem.dmem_ack = 1;
    @(negedge clk);
    dmem.dmem_ack = 0;
    chk("bubble_no_wb", wb_valid, 0);
    chk("stray_ack_stall", stall, 0);

    i = blank(); i.a2r = 1; i.en = 1; i.rw = 1; i.op0 = 3; i.s1 = 5; i.s2 = 7;
    i.func = 0; i.pc = 10'h011;
    exec(i, 0, 0);

    i = blank(); i.a2r = 1; i.en = 1; i.rw = 1; i.op0 = 5; i.func = 7;
    i.s1 = 32'h0001_0003; i.s2 = 32'h0002_0000; i.pc = 10'h012;
    exec(i, 0, 0);

    i = blank(); i.rd = 1; i.rw = 1; i.op0 = 1; i.s1 = 32'h2A5; i.pc = 10'h013;
    exec(i, 3, 32'hDEAD_BEEF);

    i = blank(); i.wr = 1; i.rw = 1; i.s1 = 32'h010; i.s2 = 32'h55; i.pc = 10'h014;
    exec(i, 2, 32'h1234_5678);

    i = blank(); i.rd = 1; i.wr = 1; i.rw = 1; i.op0 = 6; i.s1 = 32'hFFFF_F3C1;
    i.s2 = 32'h77; i.pc = 10'h015;
    exec(i, 1, 32'hCAFE_0001);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      int c;
      i = blank();
      c = $urandom_range(0, 9);
      i.s1 = $urandom; i.s2 = $urandom; i.op0 = 3'($urandom);
      i.pc = 10'($urandom); i.rw = 1'($urandom); i.cnst = 8'($urandom);
      if (c < 2) begin
        i.rd = 1'($urandom); i.wr = !i.rd | 1'($urandom);
        exec(i, $urandom_range(1, 4), $urandom);
      end else if (c < 3) begin
        i.en = 1; i.func = 7; i.a2r = 1'($urandom);
        exec(i, 0, 0);
      end else begin
        i.en = ($urandom_range(0, 5) != 0); i.a2r = 1'($urandom);
        i.c2r = 1'($urandom);
        i.func = (c == 9) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 6));
        exec(i, 0, 0);
      end
    end

    // constant load then halt
    i = blank(); i.c2r = 1; i.cnst = 8'hF0; i.rw = 1; i.op0 = 2; i.pc = 10'h020;
    exec(i, 0, 0);
    i = blank(); i.halt = 1; i.pc = 10'h021;
    exec(i, 0, 0);
    i = blank(); i.a2r = 1; i.en = 1; i.rw = 1; i.s1 = 1; i.s2 = 1;
    drive(i); in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halted_no_wb", wb_valid, 0);
      chk("halted_stall", stall, 1);
      chk("halted_sticky", halted, 1);
    end
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("halt_rst_clear", halted, 0);
    @(negedge clk);
    rst_n = 1;

    // reset in the middle of a multiply
    i = blank(); i.a2r = 1; i.en = 1; i.rw = 1; i.func = 7; i.s1 = 9; i.s2 = 9;
    @(negedge clk); drive(i); in_valid = 1;
    @(negedge clk); in_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mulrst_stall", stall, 0);
    chk("mulrst_wb_valid", wb_valid, 0);
    chk("mulrst_wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      chk("mulrst_no_wb", wb_valid, 0);
    end

    // reset in the middle of a memory access
    i = blank(); i.rd = 1; i.rw = 1; i.s1 = 32'h3FF;
    @(negedge clk); drive(i); in_valid = 1;
    @(negedge clk); in_valid = 0;
    chk("memrst_req_up", dmem.dmem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("memrst_req_drop", dmem.dmem_req, 0);
    chk("memrst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1;
    dmem.dmem_ack = 1; dmem.dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem.dmem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      chk("memrst_no_wb", wb_valid, 0);
      @(negedge clk);
    end

    i = blank(); i.a2r = 1; i.en = 1; i.rw = 1; i.op0 = 7; i.s1 = 32'hFFFF_FFFF;
    i.s2 = 2; i.func = 0; i.pc = 10'h3FF;
    exec(i, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
